// File: rtl/parity_engine_if.sv
// Bus bundle for parity_engine: TX capture, RX bit stream and error counter signals.
// The DUT connects through the slave modport and its driver through the master modport.
interface parity_engine_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_W      = 4,
  parameter int unsigned CNT_W      = 8
);
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  busy;
  logic                  par_en;
  logic [1:0]            par_typ;
  logic [LEN_W-1:0]      data_len;
  logic                  par_bit;
  logic                  par_valid;
  logic                  rx_start;
  logic                  rx_sample;
  logic                  rx_bit;
  logic                  chk_done;
  logic                  par_err;
  logic                  err_clr;
  logic [CNT_W-1:0]      err_cnt;

  modport master (
    output p_data, data_valid, busy, par_en, par_typ, data_len,
    output rx_start, rx_sample, rx_bit, err_clr,
    input  par_bit, par_valid, chk_done, par_err, err_cnt
  );

  modport slave (
    input  p_data, data_valid, busy, par_en, par_typ, data_len,
    input  rx_start, rx_sample, rx_bit, err_clr,
    output par_bit, par_valid, chk_done, par_err, err_cnt
  );
endinterface

// File: rtl/parity_engine.sv
// UART parity engine: registered TX parity generator and serial RX parity checker
// with a saturating error counter. Even/odd/mark/space, runtime frame length.
module parity_engine #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_W      = 4,
  parameter int unsigned CNT_W      = 8
) (
  input logic            clk,
  input logic            rst,
  parity_engine_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StData, StPar} rx_state_e;

  localparam logic [1:0] TypEven  = 2'b00;
  localparam logic [1:0] TypOdd   = 2'b01;
  localparam logic [1:0] TypMark  = 2'b10;

  function automatic logic f_par(input logic [DATA_WIDTH-1:0] d, input logic [1:0] typ);
    logic res;
    case (typ)
      TypEven: res = ^d;
      TypOdd:  res = ~^d;
      TypMark: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Effective frame length: 0 or out-of-range lengths mean a full-width frame.
  logic [LEN_W-1:0]      w_len;
  logic [DATA_WIDTH-1:0] w_mask;
  logic                  w_cap;

  always_comb begin
    w_len = bus.data_len;
    if (bus.data_len == '0 || bus.data_len > LEN_W'(DATA_WIDTH)) begin
      w_len = LEN_W'(DATA_WIDTH);
    end
    w_mask = '0;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      w_mask[i] = (i < int'(w_len));
    end
  end

  assign w_cap = bus.data_valid & ~bus.busy;

  // TX path registers
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_tx_en;
  logic [1:0]            r_tx_typ;
  logic                  r_cap;
  logic                  r_par_bit;
  logic                  r_par_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data      <= '0;
      r_tx_en     <= 1'b0;
      r_tx_typ    <= 2'b00;
      r_cap       <= 1'b0;
      r_par_bit   <= 1'b0;
      r_par_valid <= 1'b0;
    end else begin
      if (w_cap) begin
        r_data   <= bus.p_data & w_mask;
        r_tx_en  <= bus.par_en;
        r_tx_typ <= bus.par_typ;
      end
      r_cap       <= w_cap;
      r_par_valid <= r_cap;
      if (r_cap) begin
        r_par_bit <= r_tx_en ? f_par(r_data, r_tx_typ) : 1'b0;
      end
    end
  end

  // RX path state
  rx_state_e        r_state, w_state;
  logic             r_acc, w_acc;
  logic [LEN_W-1:0] r_cnt, w_cnt;
  logic [LEN_W-1:0] r_rx_len, w_rx_len;
  logic             r_rx_en, w_rx_en;
  logic [1:0]       r_rx_typ, w_rx_typ;
  logic             r_chk_done, w_chk_done;
  logic             r_par_err, w_par_err;
  logic [CNT_W-1:0] r_err_cnt, w_err_cnt;
  logic             w_exp;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_acc      <= 1'b0;
      r_cnt      <= '0;
      r_rx_len   <= '0;
      r_rx_en    <= 1'b0;
      r_rx_typ   <= 2'b00;
      r_chk_done <= 1'b0;
      r_par_err  <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_state    <= w_state;
      r_acc      <= w_acc;
      r_cnt      <= w_cnt;
      r_rx_len   <= w_rx_len;
      r_rx_en    <= w_rx_en;
      r_rx_typ   <= w_rx_typ;
      r_chk_done <= w_chk_done;
      r_par_err  <= w_par_err;
      r_err_cnt  <= w_err_cnt;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_acc      = r_acc;
    w_cnt      = r_cnt;
    w_rx_len   = r_rx_len;
    w_rx_en    = r_rx_en;
    w_rx_typ   = r_rx_typ;
    w_chk_done = 1'b0;
    w_par_err  = 1'b0;

    case (r_rx_typ)
      TypEven: w_exp = r_acc;
      TypOdd:  w_exp = ~r_acc;
      TypMark: w_exp = 1'b1;
      default: w_exp = 1'b0;
    endcase

    // rx_start restarts from any state and swallows a coincident sample.
    if (bus.rx_start) begin
      w_state  = StData;
      w_acc    = 1'b0;
      w_cnt    = '0;
      w_rx_len = w_len;
      w_rx_en  = bus.par_en;
      w_rx_typ = bus.par_typ;
    end else begin
      case (r_state)
        StIdle: begin
          w_state = StIdle;
        end
        StData: begin
          if (bus.rx_sample) begin
            w_acc = r_acc ^ bus.rx_bit;
            w_cnt = r_cnt + LEN_W'(1);
            if (r_cnt == r_rx_len - LEN_W'(1)) begin
              if (r_rx_en) begin
                w_state = StPar;
              end else begin
                w_state    = StIdle;
                w_chk_done = 1'b1;
              end
            end
          end
        end
        StPar: begin
          if (bus.rx_sample) begin
            w_chk_done = 1'b1;
            w_par_err  = (bus.rx_bit != w_exp);
            w_state    = StIdle;
          end
        end
        default: w_state = StIdle;
      endcase
    end

    w_err_cnt = r_err_cnt;
    if (bus.err_clr) begin
      w_err_cnt = '0;
    end else if (w_par_err && r_err_cnt != '1) begin
      w_err_cnt = r_err_cnt + CNT_W'(1);
    end
  end

  assign bus.par_bit   = r_par_bit;
  assign bus.par_valid = r_par_valid;
  assign bus.chk_done  = r_chk_done;
  assign bus.par_err   = r_par_err;
  assign bus.err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_parity_engine.sv
// Directed self-checking bench for parity_engine (CNT_W=2 to exercise saturation).
module tb_parity_engine;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   done_cnt;
  int   d0;

  parity_engine_if #(.DATA_WIDTH(8), .LEN_W(4), .CNT_W(2)) bus ();

  parity_engine #(.DATA_WIDTH(8), .LEN_W(4), .CNT_W(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial done_cnt = 0;
  always @(negedge clk) if (bus.chk_done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs_zero(input string tag);
    check({tag, "_par_bit"},   32'(bus.par_bit),   32'd0);
    check({tag, "_par_valid"}, 32'(bus.par_valid), 32'd0);
    check({tag, "_chk_done"},  32'(bus.chk_done),  32'd0);
    check({tag, "_par_err"},   32'(bus.par_err),   32'd0);
    check({tag, "_err_cnt"},   32'(bus.err_cnt),   32'd0);
  endtask

  task automatic tx(input string tag, input logic [7:0] d, input logic en,
                    input logic [1:0] typ, input logic [3:0] len, input logic exp);
    bus.p_data = d; bus.par_en = en; bus.par_typ = typ; bus.data_len = len;
    bus.data_valid = 1'b1;
    tick();
    bus.data_valid = 1'b0;
    check({tag, "_lat"}, 32'(bus.par_valid), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(bus.par_valid), 32'd1);
    check({tag, "_bit"},   32'(bus.par_bit),   32'(exp));
    bus.par_typ = ~typ;
    tick();
    check({tag, "_pulse"}, 32'(bus.par_valid), 32'd0);
    check({tag, "_hold"},  32'(bus.par_bit),   32'(exp));
  endtask

  task automatic rx_start(input logic en, input logic [1:0] typ, input logic [3:0] len);
    bus.par_en = en; bus.par_typ = typ; bus.data_len = len;
    bus.rx_start = 1'b1;
    tick();
    bus.rx_start = 1'b0;
  endtask

  task automatic rx_send(input logic b, input logic clr);
    bus.rx_sample = 1'b1; bus.rx_bit = b; bus.err_clr = clr;
    tick();
    bus.rx_sample = 1'b0; bus.rx_bit = 1'b0; bus.err_clr = 1'b0;
  endtask

  task automatic rx_frame(input logic [7:0] d, input int n, input logic en,
                          input logic [1:0] typ, input logic p, input logic clr);
    rx_start(en, typ, 4'd8);
    for (int i = 0; i < n; i++) rx_send(d[i], 1'b0);
    if (en) rx_send(p, clr);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0;
    bus.p_data = '0; bus.data_valid = 1'b0; bus.busy = 1'b0; bus.par_en = 1'b0;
    bus.par_typ = 2'b00; bus.data_len = '0; bus.rx_start = 1'b0; bus.rx_sample = 1'b0;
    bus.rx_bit = 1'b0; bus.err_clr = 1'b0;
    tick(); tick();
    check_outs_zero("reset");
    rst = 1'b1;
    tick();

    // TX directed vectors
    tx("tx_even_a5", 8'hA5, 1'b1, 2'b00, 4'd8, 1'b0);
    tx("tx_odd_a5",  8'hA5, 1'b1, 2'b01, 4'd8, 1'b1);
    tx("tx_len7_80", 8'h80, 1'b1, 2'b00, 4'd7, 1'b0);
    tx("tx_len0_80", 8'h80, 1'b1, 2'b00, 4'd0, 1'b1);
    tx("tx_len9_80", 8'h80, 1'b1, 2'b00, 4'd9, 1'b1);
    tx("tx_mark",    8'h00, 1'b1, 2'b10, 4'd8, 1'b1);
    tx("tx_space",   8'hFF, 1'b1, 2'b11, 4'd8, 1'b0);
    tx("tx_len3_0f", 8'h0F, 1'b1, 2'b00, 4'd3, 1'b1);
    tx("tx_par_off", 8'h01, 1'b0, 2'b00, 4'd8, 1'b0);

    // Back-to-back captures: 01,03,07,0F even -> 1,0,1,0
    bus.par_en = 1'b1; bus.par_typ = 2'b00; bus.data_len = 4'd8;
    bus.data_valid = 1'b1; bus.p_data = 8'h01;
    tick();
    bus.p_data = 8'h03; tick();
    check("b2b0_valid", 32'(bus.par_valid), 32'd1);
    check("b2b0_bit",   32'(bus.par_bit),   32'd1);
    bus.p_data = 8'h07; tick();
    check("b2b1_valid", 32'(bus.par_valid), 32'd1);
    check("b2b1_bit",   32'(bus.par_bit),   32'd0);
    bus.p_data = 8'h0F; tick();
    check("b2b2_valid", 32'(bus.par_valid), 32'd1);
    check("b2b2_bit",   32'(bus.par_bit),   32'd1);
    bus.data_valid = 1'b0; tick();
    check("b2b3_valid", 32'(bus.par_valid), 32'd1);
    check("b2b3_bit",   32'(bus.par_bit),   32'd0);
    tick();
    check("b2b_end", 32'(bus.par_valid), 32'd0);

    // Busy blocks capture
    bus.busy = 1'b1; bus.data_valid = 1'b1; bus.p_data = 8'h01;
    tick(); tick();
    check("busy_valid", 32'(bus.par_valid), 32'd0);
    tick();
    check("busy_valid2", 32'(bus.par_valid), 32'd0);
    check("busy_bit",    32'(bus.par_bit),   32'd0);
    bus.busy = 1'b0; bus.data_valid = 1'b0;

    // RX even, 8'h01, parity 1 good / parity 0 bad
    rx_frame(8'h01, 8, 1'b1, 2'b00, 1'b1, 1'b0);
    check("rx_good_done", 32'(bus.chk_done), 32'd1);
    check("rx_good_err",  32'(bus.par_err),  32'd0);
    check("rx_good_cnt",  32'(bus.err_cnt),  32'd0);
    tick();
    check("rx_done_pulse", 32'(bus.chk_done), 32'd0);
    rx_frame(8'h01, 8, 1'b1, 2'b00, 1'b0, 1'b0);
    check("rx_bad_done", 32'(bus.chk_done), 32'd1);
    check("rx_bad_err",  32'(bus.par_err),  32'd1);
    check("rx_bad_cnt",  32'(bus.err_cnt),  32'd1);

    // Odd and mark on RX: 8'h03 odd expects 1; mark expects 1
    rx_frame(8'h03, 8, 1'b1, 2'b01, 1'b1, 1'b0);
    check("rx_odd_err", 32'(bus.par_err), 32'd0);
    rx_frame(8'h00, 8, 1'b1, 2'b10, 1'b0, 1'b0);
    check("rx_mark_err", 32'(bus.par_err), 32'd1);
    check("rx_mark_cnt", 32'(bus.err_cnt), 32'd2);

    // Saturation at 3, then clear coincident with an error
    for (int k = 0; k < 5; k++) rx_frame(8'h01, 8, 1'b1, 2'b00, 1'b0, 1'b0);
    check("sat_cnt", 32'(bus.err_cnt), 32'd3);
    rx_frame(8'h01, 8, 1'b1, 2'b00, 1'b0, 1'b1);
    check("clr_err", 32'(bus.par_err), 32'd1);
    check("clr_cnt", 32'(bus.err_cnt), 32'd0);

    // No parity, L=4: done after 4th sample
    rx_start(1'b0, 2'b00, 4'd4);
    for (int i = 0; i < 3; i++) rx_send(1'b1, 1'b0);
    check("nopar_early", 32'(bus.chk_done), 32'd0);
    rx_send(1'b1, 1'b0);
    check("nopar_done", 32'(bus.chk_done), 32'd1);
    check("nopar_err",  32'(bus.par_err),  32'd0);

    // Abort after 3 bits, restart coincident with a discarded sample, then good frame
    tick();
    d0 = done_cnt;
    rx_start(1'b1, 2'b00, 4'd8);
    for (int i = 0; i < 3; i++) rx_send(1'b1, 1'b0);
    bus.rx_start = 1'b1; bus.rx_sample = 1'b1; bus.rx_bit = 1'b1;
    tick();
    bus.rx_start = 1'b0; bus.rx_sample = 1'b0; bus.rx_bit = 1'b0;
    bus.par_typ = 2'b11;
    for (int i = 0; i < 8; i++) rx_send((i < 2), 1'b0);
    rx_send(1'b0, 1'b0);
    check("abort_done", 32'(bus.chk_done), 32'd1);
    check("abort_err",  32'(bus.par_err),  32'd0);
    tick();
    check("abort_once", 32'(done_cnt - d0), 32'd1);

    // Mid-frame reset with nonzero outputs
    rx_frame(8'h01, 8, 1'b1, 2'b00, 1'b0, 1'b0);
    tx("pre_rst_mark", 8'h00, 1'b1, 2'b10, 4'd8, 1'b1);
    rx_start(1'b1, 2'b00, 4'd8);
    for (int i = 0; i < 3; i++) rx_send(1'b1, 1'b0);
    bus.data_valid = 1'b1; bus.rx_sample = 1'b1; rst = 1'b0;
    tick();
    check_outs_zero("midrst");
    tick();
    check_outs_zero("midrst2");
    bus.data_valid = 1'b0; bus.rx_sample = 1'b0; rst = 1'b1;
    tick();
    d0 = done_cnt;
    for (int i = 0; i < 9; i++) rx_send(1'b1, 1'b0);
    tick();
    check("idle_ignores", 32'(done_cnt - d0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
